// File: rtl/tdm_demux_16.sv
// Serial-to-parallel TDM receiver: steers slot n of each frame to dout[n] and strobes
// frame_valid when a full frame lands. Define TDM_PARITY_EN for an even-parity slot per frame.
module tdm_demux_16 #(
  parameter int LANES = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [0:LANES-1] dout,
  output logic             frame_valid,
  output logic             sync_err,
`ifdef TDM_PARITY_EN
  output logic             par_err,
`endif
  output logic [SEL_W-1:0] slot,
  output logic             busy
);

  // Handshake: din/frame_start are sampled only on edges where din_valid=1; when
  // din_valid=0 every register holds and the pulse outputs drop to 0.

`ifdef TDM_PARITY_EN
  localparam int CNT_W = SEL_W + 1;
  localparam int LAST  = LANES;
`else
  localparam int CNT_W = SEL_W;
  localparam int LAST  = LANES - 1;
`endif

  typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [0:LANES-1] shadow;

  assign slot = cnt[SEL_W-1:0];
  // busy is the FSM state register itself, so it doubles as the state debug view.
  assign busy = (state == COLLECT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      cnt         <= '0;
      shadow      <= '0;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_PARITY_EN
      par_err     <= 1'b0;
`endif
      if (din_valid) begin
        if (frame_start) begin
          // A start mid-frame abandons the partial frame but still opens a new one.
          shadow[0] <= din;
          cnt       <= CNT_W'(1);
          state     <= COLLECT;
          if (state == COLLECT && cnt != '0)
            sync_err <= 1'b1;
        end else if (state == COLLECT) begin
          if (cnt == '0) begin
            sync_err <= 1'b1;
            state    <= HUNT;
          end else if (cnt == CNT_W'(LAST)) begin
            cnt <= '0;
`ifdef TDM_PARITY_EN
            if (din == ^shadow) begin
              dout        <= shadow;
              frame_valid <= 1'b1;
            end else begin
              par_err <= 1'b1;
            end
`else
            shadow[LANES-1] <= din;
            dout            <= {shadow[0:LANES-2], din};
            frame_valid     <= 1'b1;
`endif
          end else begin
            shadow[cnt[SEL_W-1:0]] <= din;
            cnt                    <= cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
